fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues sequential requests to a variable-latency instruction memory. Returned words are buffered with their addresses in a small in-order prefetch queue, so that pipeline stalls and memory latency are decoupled. It accepts the branch redirect from the memory stage, flushes stale work and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 4, prefetch queue entries and maximum in-flight requests; power of 2, ≥2
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address, valid with imem_req
- imem_ack  in  1  memory accepts the request this cycle (imem_req & imem_ack = issue)
- imem_rvalid  in  1  response valid; responses return in issue order, ≥1 cycle after issue
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- redirect  in  1  taken branch (takeBranch)
- redirect_pc  in  32  branch target (PC_M); bits [1:0] ignored, treated as 0
- stall  in  1  downstream not ready; head is not consumed
- instr_valid  out  1  queue head valid
- instruction  out  32  head instruction; 32'h0000_0013 (NOP) when queue empty
- instr_address  out  32  head PC; 0 when queue empty

## Operation
- State: fpc (next issue address), rpc (address of next expected response), queue (DEPTH × {instr, addr}), out_cnt (in-flight, 0..DEPTH), drop_cnt (responses to discard, 0..DEPTH), count (queue occupancy).
- Issue: imem_req = !redirect & (out_cnt + count < DEPTH). imem_addr = fpc. On issue: fpc += 4 (mod 2^32), out_cnt++.
- Response: imem_rvalid decrements out_cnt. If drop_cnt ≠ 0: discard, drop_cnt--. Otherwise write {imem_rdata, rpc} at tail, rpc += 4.
- Consume: head pops when instr_valid & !stall.
- Simultaneous issue/response/pop in one cycle: all counters update with net effect. The credit rule guarantees the queue never overflows.
- imem_rvalid with out_cnt = 0 is a protocol error: ignored, no state change.
- Redirect (highest priority): queue emptied; no pop occurs. fpc and rpc take {redirect_pc[31:2], 2'b00}. drop_cnt = out_cnt − imem_rvalid (all survivors become stale). out_cnt updates normally. Any same-cycle response is discarded. imem_req is forced low this cycle.
- Redirect while drop_cnt ≠ 0: the same formula applies. It covers the older drops because out_cnt ≥ drop_cnt.

## Timing
- Reset asserted (async): fpc = RESET_PC, rpc = RESET_PC, all counters 0, queue empty. Outputs: instr_valid = 0, instruction = 32'h0000_0013, instr_address = 0. imem_req rises combinationally once reset deasserts (credit available). imem_addr = RESET_PC.
- Reset mid-operation discards in-flight requests; instruction memory shares the reset.
- Queue-head outputs are registered-state driven; there is no bypass from imem_rdata.
- A response arriving in cycle N is visible at the head in cycle N+1 if the queue was empty.
- Redirect in cycle N:
  - first request to the target at N+1;
  - with 1-cycle memory, the response arrives at N+2 and instr_valid is asserted at N+3.
- Minimum latency from reset release to first instr_valid: 2 cycles with 1-cycle memory.
- Steady state with 1-cycle memory and no stall: one instruction per cycle.
- Full queue (count = DEPTH): imem_req = 0 until a pop frees a credit. A pop at cycle N allows an issue at N+1 when out_cnt + count < DEPTH at N+1.

## Test plan
- Reset release, memory acks every cycle with 1-cycle latency, stall = 0 → instr_valid at cycle 2, instr_address sequence 0x0, 0x4, 0x8 …, one per cycle, no gaps.
- Hold stall = 1 for 10 cycles → exactly DEPTH (4) requests issued, then imem_req = 0. After stall drops: 4 queued words drain in order (0x0 … 0xC) and fetch resumes at 0x10 with no loss or duplicate.
- Memory latency 3 cycles, 2 requests in flight, then redirect to 0x100 → both stale responses dropped. Next instr_address = 0x100, queue empty in the redirect's following cycle.
- Redirect in the same cycle as imem_rvalid and a pop → response discarded, no pop recorded, drop_cnt = out_cnt − 1, next head = redirect_pc. Repeat with redirect_pc = 0x203 and check the head address = 0x200.
- Second redirect while drop_cnt = 2 → all older responses are still discarded and only words from the second target appear.
- Assert reset mid-stream with a full queue → instr_valid falls and instruction = 0x13 immediately (async). After release, fetch restarts at RESET_PC. A spurious imem_rvalid while out_cnt = 0 causes no state change.

Source files
------------

// File: rtl/fetch_prefetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit_if
// Instruction-memory bus between the fetch front end and the instruction
// memory.
//   imem_req    : fetch request valid (driven by the fetch unit)
//   imem_addr   : word-aligned fetch address, valid with imem_req
//   imem_ack    : memory accepts the request this cycle
//   imem_rvalid : response valid; responses return in issue order
//   imem_rdata  : instruction word, valid with imem_rvalid
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_prefetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
// Instruction fetch front end feeding the IF/ID register. Owns the fetch PC,
// issues sequential requests to a variable-latency instruction memory and
// buffers returned words with their addresses in an in-order prefetch queue.
// A redirect flushes the queue, marks all in-flight responses stale and
// restarts fetch at the target.
//
// Parameters:
//   DEPTH    : queue entries and maximum in-flight requests (power of 2, >= 2)
//   RESET_PC : fetch address after reset
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   imem          : instruction-memory bus (master side)
//   redirect      : taken branch from the memory stage
//   redirect_pc   : branch target, bits [1:0] ignored
//   stall         : downstream not ready, head is held
//   instr_valid   : queue head valid
//   instruction   : head instruction, NOP (32'h13) when empty
//   instr_address : head PC, 0 when empty
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset,
   fetch_prefetch_unit_if.master        imem,
   input  logic                         redirect,
   input  logic [31:0]                  redirect_pc,
   input  logic                         stall,
   output logic                         instr_valid,
   output logic [31:0]                  instruction,
   output logic [31:0]                  instr_address
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 1;

   logic [31:0]   fpc;
   logic [31:0]   rpc;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   addr_q  [DEPTH];

   logic [31:0]   target;
   logic          credit;
   logic          issue;
   logic          rsp;
   logic          drop_rsp;
   logic          push;
   logic          pop;

   assign target = {redirect_pc[31:2], 2'b00};

   // Every slot is either occupied or reserved for an in-flight response,
   // so the queue cannot overflow.
   assign credit = ({1'b0, out_cnt} + {1'b0, count}) < SW'(DEPTH);

   assign imem.imem_req  = reset & ~redirect & credit;
   assign imem.imem_addr = fpc;

   assign issue    = imem.imem_req & imem.imem_ack;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp      = imem.imem_rvalid & (out_cnt != '0);
   assign drop_rsp = rsp & (drop_cnt != '0);
   assign push     = rsp & ~redirect & (drop_cnt == '0);

   assign instr_valid   = (count != '0);
   assign pop           = instr_valid & ~stall & ~redirect;
   assign instruction   = instr_valid ? instr_q[head] : 32'h0000_0013;
   assign instr_address = instr_valid ? addr_q[head]  : 32'h0000_0000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc      <= RESET_PC;
         rpc      <= RESET_PC;
         out_cnt  <= '0;
         drop_cnt <= '0;
         count    <= '0;
         head     <= '0;
         tail     <= '0;
      end else begin
         // imem_req is low during a redirect, so issue is 0 then.
         out_cnt <= out_cnt + CW'(issue) - CW'(rsp);
         if (redirect) begin
            fpc      <= target;
            rpc      <= target;
            // Every response still outstanding after this cycle is stale;
            // this also absorbs any drops left over from an earlier redirect.
            drop_cnt <= out_cnt - CW'(rsp);
            count    <= '0;
            head     <= '0;
            tail     <= '0;
         end else begin
            if (issue) begin
               fpc <= fpc + 32'd4;
            end
            if (drop_rsp) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
               rpc  <= rpc + 32'd4;
               tail <= tail + PW'(1);
            end
            if (pop) begin
               head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Queue storage needs no reset: entries are only read while count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[tail] <= imem.imem_rdata;
         addr_q[tail]  <= rpc;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_address;

   fetch_prefetch_unit_if bus ();

   fetch_prefetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus.master),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .stall         (stall),
      .instr_valid   (instr_valid),
      .instruction   (instruction),
      .instr_address (instr_address)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   pend_t       pend[$];
   int unsigned cyc   = 0;
   int unsigned lat   = 1;
   int unsigned n_iss = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mem_clear();
      pend.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
   endtask

   // Advance one cycle: record this cycle's issue, then present the response
   // for the new cycle.
   task automatic tick();
      logic        iss;
      logic [31:0] ia;
      #1;
      iss = bus.imem_req & bus.imem_ack;
      ia  = bus.imem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
         mem_clear();
      end else begin
         if (iss) begin
            pend.push_back('{ia, cyc - 1 + lat});
            n_iss++;
         end
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
         end
      end
   endtask

   task automatic expect_head(input string nm, input logic v, input logic [31:0] a);
      chk({nm, " valid"}, 32'(instr_valid), 32'(v));
      chk({nm, " addr"}, instr_address, v ? a : 32'h0);
      chk({nm, " instr"}, instruction, v ? mem_word(a) : 32'h0000_0013);
   endtask

   // Leaves the bench in cycle 0 after reset release.
   task automatic do_reset(input int unsigned l);
      reset = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      mem_clear();
      tick();
      tick();
      lat   = l;
      n_iss = 0;
      reset = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst_n;
      bit          stall;
      bit          redir;
      logic [31:0] rpc;
      bit          e_valid;
      logic [31:0] e_addr;
      bit          e_req;
      logic [31:0] e_iaddr;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                       input bit ev, input logic [31:0] ea, input bit er, input logic [31:0] eia);
      vec_t v;
      v.rst_n = r; v.stall = s; v.redir = rd; v.rpc = rp;
      v.e_valid = ev; v.e_addr = ea; v.e_req = er; v.e_iaddr = eia;
      tbl.push_back(v);
   endtask

   initial begin
      bus.imem_ack = 1'b1;
      mem_clear();

      //   rst st rd rpc            valid addr          req iaddr
      addv(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
      addv(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
      addv(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0);
      addv(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4);
      addv(1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h8);
      addv(1, 0, 0, 32'h0,        1, 32'h4,        1, 32'hC);
      addv(1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h10);
      addv(1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h14);
      addv(1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h18);
      addv(1, 1, 0, 32'h0,        1, 32'hC,        0, 32'h1C);
      addv(1, 1, 0, 32'h0,        1, 32'hC,        0, 32'h1C);
      addv(1, 1, 0, 32'h0,        1, 32'hC,        0, 32'h1C);
      addv(1, 0, 0, 32'h0,        1, 32'hC,        0, 32'h1C);
      addv(1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h1C);
      addv(1, 0, 0, 32'h0,        1, 32'h14,       1, 32'h20);
      addv(1, 0, 0, 32'h0,        1, 32'h18,       1, 32'h24);
      addv(1, 0, 0, 32'h0,        1, 32'h1C,       1, 32'h28);
      addv(1, 0, 0, 32'h0,        1, 32'h20,       1, 32'h2C);
      addv(1, 0, 1, 32'h203,      1, 32'h24,       0, 32'h30);
      addv(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200);
      addv(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204);
      addv(1, 0, 0, 32'h0,        1, 32'h200,      1, 32'h208);
      addv(1, 0, 0, 32'h0,        1, 32'h204,      1, 32'h20C);

      tick();
      lat = 1;
      foreach (tbl[i]) begin
         reset       = tbl[i].rst_n;
         stall       = tbl[i].stall;
         redirect    = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         if (!reset) mem_clear();
         #1;
         expect_head($sformatf("tbl[%0d]", i), tbl[i].e_valid, tbl[i].e_addr);
         chk($sformatf("tbl[%0d] req", i), 32'(bus.imem_req), 32'(tbl[i].e_req));
         chk($sformatf("tbl[%0d] imem_addr", i), bus.imem_addr, tbl[i].e_iaddr);
         tick();
      end
      redirect = 1'b0;

      // B: latency 3, two in flight, redirect to 0x100 at cycle 2
      do_reset(3);
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      #1 chk("B redir req", 32'(bus.imem_req), 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      expect_head("B c3", 1'b0, 32'h0);
      chk("B c3 imem_addr", bus.imem_addr, 32'h100);
      for (int c = 4; c <= 6; c++) begin
         tick();
         expect_head($sformatf("B c%0d", c), 1'b0, 32'h0);
      end
      tick(); expect_head("B c7", 1'b1, 32'h100);
      tick(); expect_head("B c8", 1'b1, 32'h104);

      // C: second redirect while two stale responses are pending
      do_reset(3);
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_pc = 32'h300;
      #1 chk("C 2nd redir req", 32'(bus.imem_req), 32'h0);
      tick();
      redirect = 1'b0;
      #1 chk("C c4 imem_addr", bus.imem_addr, 32'h300);
      for (int c = 4; c <= 7; c++) begin
         if (c > 4) tick();
         expect_head($sformatf("C c%0d", c), 1'b0, 32'h0);
      end
      tick(); expect_head("C c8", 1'b1, 32'h300);
      tick(); expect_head("C c9", 1'b1, 32'h304);

      // D: latency 2, redirect with same-cycle response and pop, unaligned target
      do_reset(2);
      tick(); tick(); tick();
      expect_head("D c3", 1'b1, 32'h0);
      chk("D c3 rvalid", 32'(bus.imem_rvalid), 32'h1);
      redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      #1;
      expect_head("D c4", 1'b0, 32'h0);
      chk("D c4 imem_addr", bus.imem_addr, 32'h200);
      tick(); expect_head("D c5", 1'b0, 32'h0);
      tick(); expect_head("D c6", 1'b0, 32'h0);
      tick(); expect_head("D c7", 1'b1, 32'h200);
      tick(); expect_head("D c8", 1'b1, 32'h204);

      // E: stall from reset fills the queue, spurious response, drain, async reset
      do_reset(1);
      stall = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      chk("E issues", n_iss, 32'd4);
      chk("E req full", 32'(bus.imem_req), 32'h0);
      expect_head("E full", 1'b1, 32'h0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
      expect_head("E spurious", 1'b1, 32'h0);
      chk("E spurious req", 32'(bus.imem_req), 32'h0);
      stall = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1 expect_head($sformatf("E drain%0d", k), 1'b1, 32'(k * 4));
         tick();
      end
      stall = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      expect_head("E refill", 1'b1, 32'h18);
      #2;
      reset = 1'b0;
      mem_clear();
      #1;
      expect_head("E async rst", 1'b0, 32'h0);
      chk("E rst req", 32'(bus.imem_req), 32'h0);
      tick();
      reset = 1'b1;
      stall = 1'b0;
      #1;
      chk("E restart req", 32'(bus.imem_req), 32'h1);
      chk("E restart addr", bus.imem_addr, 32'h0);
      tick(); expect_head("E restart c1", 1'b0, 32'h0);
      tick(); expect_head("E restart c2", 1'b1, 32'h0);
      tick(); expect_head("E restart c3", 1'b1, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
